// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller.
package dmem_pkg;

    // Access size as carried on req_size_i; 5..7 are undefined and fault.
    typedef enum logic [2:0] {
        SZ_B  = 3'd0,
        SZ_H  = 3'd1,
        SZ_W  = 3'd2,
        SZ_BU = 3'd3,
        SZ_HU = 3'd4
    } size_e;

    // Controller mode: zero-fill after reset, then normal service.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatting: store byte enables and replication,
// request fault decode, and load byte/half extraction with extension.
import dmem_pkg::*;

module dmem_lane_fmt #(
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  size_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        fault_o,
    input  logic [31:0] ld_word_i,
    input  logic [2:0]  ld_size_i,
    input  logic [1:0]  ld_lane_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Request side: byte enables, lane-replicated store data and fault decode.
    always_comb begin
        be_o    = '0;
        wdata_o = '0;
        fault_o = 1'b0;
        case (size_i)
            SZ_B, SZ_BU: begin
                be_o    = 4'b0001 << addr_i[1:0];
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_H, SZ_HU: begin
                be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                fault_o = addr_i[0];
            end
            SZ_W: begin
                be_o    = '1;
                wdata_o = wdata_i;
                fault_o = (addr_i[1:0] != 2'b00);
            end
            default: fault_o = 1'b1;
        endcase
        // Unsigned sizes only make sense for loads.
        if (we_i && ((size_i == SZ_BU) || (size_i == SZ_HU))) begin
            fault_o = 1'b1;
        end
        if ({2'b00, addr_i[31:2]} >= DEPTH_WORDS) begin
            fault_o = 1'b1;
        end
    end

    // Response side: pick the addressed lane and sign/zero extend.
    always_comb begin
        lane_byte = 8'(ld_word_i >> {ld_lane_i, 3'b000});
        lane_half = ld_lane_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        case (ld_size_i)
            SZ_B:    ld_data_o = {{24{lane_byte[7]}}, lane_byte};
            SZ_BU:   ld_data_o = {24'h0, lane_byte};
            SZ_H:    ld_data_o = {{16{lane_half[15]}}, lane_half};
            SZ_HU:   ld_data_o = {16'h0, lane_half};
            SZ_W:    ld_data_o = ld_word_i;
            default: ld_data_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-port data memory controller with byte/half/word access,
// fixed response latency, fault reporting and optional zero-fill on reset.
import dmem_pkg::*;

module dmem_ctrl #(
    parameter int unsigned DEPTH_WORDS    = 4096,
    parameter int unsigned RD_LAT         = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_size_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            init_we;

    logic            accept;
    logic [AW-1:0]   req_idx;
    logic [3:0]      fmt_be;
    logic [31:0]     fmt_wdata;
    logic            fmt_fault;
    logic [31:0]     ld_data;

    logic            mem_we;
    logic            mem_re;
    logic [AW-1:0]   mem_idx;
    logic [3:0]      mem_be;
    logic [31:0]     mem_wdata;
    logic [31:0]     mem [DEPTH_WORDS];
    logic [31:0]     mem_rdata_q;

    logic            s1_valid_q, s1_valid_d;
    logic            s1_err_q,   s1_err_d;
    logic            s1_zero_q,  s1_zero_d;
    logic [2:0]      s1_size_q,  s1_size_d;
    logic [1:0]      s1_lane_q,  s1_lane_d;
    logic [31:0]     s1_rdata;

    // Mode register and zero-fill counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next mode, fill progress, request readiness.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_we     = 1'b0;
        req_ready_o = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we   = !rst;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH_WORDS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                req_ready_o = !rst;
            end
        endcase
    end

    assign accept  = req_valid_i && req_ready_o;
    assign req_idx = req_addr_i[AW+1:2];

    dmem_lane_fmt #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_lane_fmt (
        .we_i      (req_we_i),
        .addr_i    (req_addr_i),
        .wdata_i   (req_wdata_i),
        .size_i    (req_size_i),
        .be_o      (fmt_be),
        .wdata_o   (fmt_wdata),
        .fault_o   (fmt_fault),
        .ld_word_i (mem_rdata_q),
        .ld_size_i (s1_size_q),
        .ld_lane_i (s1_lane_q),
        .ld_data_o (ld_data)
    );

    // RAM port: zero-fill writes in INIT, fault-free stores in RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = req_idx;
        mem_be    = fmt_be;
        mem_wdata = fmt_wdata;
        if (init_we) begin
            mem_we    = 1'b1;
            mem_idx   = clr_cnt_q;
            mem_be    = '1;
            mem_wdata = '0;
        end else if (accept && req_we_i && !fmt_fault) begin
            mem_we = 1'b1;
        end
        mem_re = accept && !req_we_i && !fmt_fault;
    end

    // Byte-enable RAM with registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
        if (mem_re) begin
            mem_rdata_q <= mem[req_idx];
        end
    end

    // First response stage: metadata captured only on acceptance so outputs hold.
    always_comb begin
        s1_valid_d = accept;
        s1_err_d   = s1_err_q;
        s1_zero_d  = s1_zero_q;
        s1_size_d  = s1_size_q;
        s1_lane_d  = s1_lane_q;
        if (accept) begin
            s1_err_d  = fmt_fault;
            s1_zero_d = fmt_fault || req_we_i;
            s1_size_d = req_size_i;
            s1_lane_d = req_addr_i[1:0];
        end
        s1_rdata = s1_zero_q ? '0 : ld_data;
    end

    // First response stage registers; zero flag masks the unreset RAM output.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_zero_q  <= 1'b1;
            s1_size_q  <= '0;
            s1_lane_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_err_q   <= s1_err_d;
            s1_zero_q  <= s1_zero_d;
            s1_size_q  <= s1_size_d;
            s1_lane_q  <= s1_lane_d;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic        s2_valid_q, s2_valid_d;
        logic        s2_err_q,   s2_err_d;
        logic [31:0] s2_rdata_q, s2_rdata_d;

        // Extra output stage, loaded only when stage one holds a response.
        always_comb begin
            s2_valid_d = s1_valid_q;
            s2_err_d   = s2_err_q;
            s2_rdata_d = s2_rdata_q;
            if (s1_valid_q) begin
                s2_err_d   = s1_err_q;
                s2_rdata_d = s1_rdata;
            end
            rsp_valid_o = s2_valid_q;
            rsp_err_o   = s2_err_q;
            rsp_rdata_o = s2_rdata_q;
        end

        // Output stage registers, flushed by reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                s2_valid_q <= 1'b0;
                s2_err_q   <= 1'b0;
                s2_rdata_q <= '0;
            end else begin
                s2_valid_q <= s2_valid_d;
                s2_err_q   <= s2_err_d;
                s2_rdata_q <= s2_rdata_d;
            end
        end
    end else begin : g_lat1
        // Responses driven straight from stage one.
        always_comb begin
            rsp_valid_o = s1_valid_q;
            rsp_err_o   = s1_err_q;
            rsp_rdata_o = s1_rdata;
        end
    end

endmodule
